// File: rtl/acquisition_ctrl.sv
// acquisition_ctrl: sequences one oscilloscope capture on the conditioned
// sample stream. It fills the pre-trigger part of the buffer, waits for an
// edge or forced trigger, counts the post-trigger samples and then reports done.
//
// Ports
//   clk_i          system clock
//   rst            synchronous reset, active-low
//   sample_data_i  sample from the ADC block
//   sample_rdy_i   one-cycle sample valid
//   reg_si_*       register write bus (data / address / write strobe)
//   buf_data_o     sample to the capture buffer
//   buf_wr_o       one-cycle buffer write strobe (one cycle after acceptance)
//   trigger_o      marks the buffer write of the trigger sample
//   done_o         capture complete, held until START, STOP or reset
//   state_o        current state encoding
//
// state     | meaning
// IDLE  (0) | no capture armed, samples ignored
// PRE   (1) | storing the pre-trigger samples, trigger ignored
// WAIT  (2) | storing circularly, looking for the trigger
// POST  (3) | storing the post-trigger samples
// DONE  (4) | capture complete, samples ignored
module acquisition_ctrl #(
  parameter int BITS_ADC              = 8,
  parameter int REG_DATA_WIDTH        = 16,
  parameter int REG_ADDR_WIDTH        = 8,
  parameter int COUNTER_WIDTH         = 16,
  parameter int DEFAULT_PRETRIGGER    = 0,
  parameter int DEFAULT_NUM_SAMPLES   = 256,
  parameter int DEFAULT_TRIGGER_VALUE = 128,
  parameter int ADDR_REQUEST          = 3,
  parameter int ADDR_TRIGGER_SETTINGS = 4,
  parameter int ADDR_TRIGGER_VALUE    = 5,
  parameter int ADDR_NUM_SAMPLES      = 6,
  parameter int ADDR_PRETRIGGER       = 7
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic [BITS_ADC-1:0]       sample_data_i,
  input  logic                      sample_rdy_i,
  input  logic [REG_DATA_WIDTH-1:0] reg_si_data,
  input  logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
  input  logic                      reg_si_rdy,
  output logic [BITS_ADC-1:0]       buf_data_o,
  output logic                      buf_wr_o,
  output logic                      trigger_o,
  output logic                      done_o,
  output logic [2:0]                state_o
);

  localparam int CW = COUNTER_WIDTH;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]          state_q, state_d;
  // cfg_* are the bus-visible registers, wk_* the copies latched at START
  logic                cfg_edge_q, cfg_edge_d, wk_edge_q, wk_edge_d;
  logic [BITS_ADC-1:0] cfg_level_q, cfg_level_d, wk_level_q, wk_level_d;
  logic [CW-1:0]       cfg_num_q, cfg_num_d, wk_num_q, wk_num_d;
  logic [CW-1:0]       cfg_pre_q, cfg_pre_d, wk_pre_q, wk_pre_d;
  logic [CW-1:0]       pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic [BITS_ADC-1:0] prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic                force_q, force_d;
  logic [BITS_ADC-1:0] buf_data_q, buf_data_d;
  logic                buf_wr_q, buf_wr_d, trigger_q, trigger_d;

  logic                req_wr, cmd_stop, cmd_start, cmd_force;
  logic                accept, rise_hit, fall_hit, fire, short_cap, pre_last;
  logic [CW:0]         pre_plus1;

  always_comb begin
    req_wr    = reg_si_rdy && (reg_si_addr == REG_ADDR_WIDTH'(ADDR_REQUEST));
    cmd_stop  = req_wr && reg_si_data[1];
    cmd_start = req_wr && reg_si_data[0] && !reg_si_data[1];
    cmd_force = req_wr && reg_si_data[2];
    // a sample coinciding with a START or STOP write is dropped
    accept    = sample_rdy_i && !cmd_stop && !cmd_start &&
                ((state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST));
    rise_hit  = prev_valid_q && (prev_q < wk_level_q) && (sample_data_i >= wk_level_q);
    fall_hit  = prev_valid_q && (prev_q > wk_level_q) && (sample_data_i <= wk_level_q);
    fire      = accept && (state_q == S_WAIT) &&
                (force_q || (wk_edge_q ? fall_hit : rise_hit));
    pre_plus1 = {1'b0, wk_pre_q} + (CW+1)'(1);
    // no post-trigger samples left after the trigger sample itself
    short_cap = ({1'b0, wk_num_q} <= pre_plus1);
    pre_last  = ((pre_cnt_q + CW'(1)) == wk_pre_q);
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (cmd_stop) begin
      state_d = S_IDLE;
    end else if (cmd_start) begin
      state_d = (cfg_pre_q == '0) ? S_WAIT : S_PRE;
    end else if (accept) begin
      case (state_q)
        S_PRE:   if (pre_last) state_d = S_WAIT;
        S_WAIT:  if (fire) state_d = short_cap ? S_DONE : S_POST;
        S_POST:  if (post_cnt_q == CW'(1)) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM: outputs and datapath next values
  always_comb begin
    buf_wr_d     = accept;
    buf_data_d   = accept ? sample_data_i : buf_data_q;
    trigger_d    = fire;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    prev_d       = accept ? sample_data_i : prev_q;
    prev_valid_d = prev_valid_q || accept;
    force_d      = force_q;
    wk_edge_d    = wk_edge_q;
    wk_level_d   = wk_level_q;
    wk_num_d     = wk_num_q;
    wk_pre_d     = wk_pre_q;
    cfg_edge_d   = cfg_edge_q;
    cfg_level_d  = cfg_level_q;
    cfg_num_d    = cfg_num_q;
    cfg_pre_d    = cfg_pre_q;

    if (cmd_stop || cmd_start) begin
      pre_cnt_d    = '0;
      post_cnt_d   = '0;
      prev_valid_d = 1'b0;
      force_d      = 1'b0;
    end else begin
      if (accept && state_q == S_PRE) pre_cnt_d = pre_cnt_q + CW'(1);
      if (fire) post_cnt_d = wk_num_q - wk_pre_q - CW'(1);
      else if (accept && state_q == S_POST) post_cnt_d = post_cnt_q - CW'(1);
      if (fire) force_d = 1'b0;
      else if (cmd_force && state_q == S_WAIT) force_d = 1'b1;
    end

    if (cmd_start) begin
      wk_edge_d  = cfg_edge_q;
      wk_level_d = cfg_level_q;
      wk_num_d   = cfg_num_q;
      wk_pre_d   = cfg_pre_q;
    end

    if (reg_si_rdy) begin
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_TRIGGER_SETTINGS)) cfg_edge_d = reg_si_data[0];
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_TRIGGER_VALUE)) cfg_level_d = reg_si_data[BITS_ADC-1:0];
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_NUM_SAMPLES)) cfg_num_d = reg_si_data[CW-1:0];
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_PRETRIGGER)) cfg_pre_d = reg_si_data[CW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      buf_wr_q     <= 1'b0;
      buf_data_q   <= '0;
      trigger_q    <= 1'b0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_q      <= 1'b0;
      cfg_edge_q   <= 1'b0;
      cfg_level_q  <= BITS_ADC'(DEFAULT_TRIGGER_VALUE);
      cfg_num_q    <= CW'(DEFAULT_NUM_SAMPLES);
      cfg_pre_q    <= CW'(DEFAULT_PRETRIGGER);
      wk_edge_q    <= 1'b0;
      wk_level_q   <= BITS_ADC'(DEFAULT_TRIGGER_VALUE);
      wk_num_q     <= CW'(DEFAULT_NUM_SAMPLES);
      wk_pre_q     <= CW'(DEFAULT_PRETRIGGER);
    end else begin
      buf_wr_q     <= buf_wr_d;
      buf_data_q   <= buf_data_d;
      trigger_q    <= trigger_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      force_q      <= force_d;
      cfg_edge_q   <= cfg_edge_d;
      cfg_level_q  <= cfg_level_d;
      cfg_num_q    <= cfg_num_d;
      cfg_pre_q    <= cfg_pre_d;
      wk_edge_q    <= wk_edge_d;
      wk_level_q   <= wk_level_d;
      wk_num_q     <= wk_num_d;
      wk_pre_q     <= wk_pre_d;
    end
  end

  assign buf_data_o = buf_data_q;
  assign buf_wr_o   = buf_wr_q;
  assign trigger_o  = trigger_q;
  assign done_o     = (state_q == S_DONE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_acquisition_ctrl.sv
module tb_acquisition_ctrl;

  logic        clk_i = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sample_data_i = '0;
  logic        sample_rdy_i = 1'b0;
  logic [15:0] reg_si_data = '0;
  logic [7:0]  reg_si_addr = '0;
  logic        reg_si_rdy = 1'b0;
  logic [7:0]  buf_data_o;
  logic        buf_wr_o, trigger_o, done_o;
  logic [2:0]  state_o;

  acquisition_ctrl dut (
    .clk_i(clk_i), .rst(rst),
    .sample_data_i(sample_data_i), .sample_rdy_i(sample_rdy_i),
    .reg_si_data(reg_si_data), .reg_si_addr(reg_si_addr), .reg_si_rdy(reg_si_rdy),
    .buf_data_o(buf_data_o), .buf_wr_o(buf_wr_o), .trigger_o(trigger_o),
    .done_o(done_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A capture is described by how many samples have been stored before and
  // after the trigger; the state seen outside follows from those counts.
  int  c_edge, c_lvl, c_num, c_pre;
  int  w_edge, w_lvl, w_num, w_pre;
  bit  m_active, m_done, m_trig, m_force, m_pv;
  int  m_prev, n_pre, n_post, tgt;
  bit  exp_wr, exp_trig, exp_done;
  int  exp_data, exp_state;
  int  m_wr;
  bit  is_req, stp, sta, in_wait, fired;

  task automatic model_reset();
    c_edge = 0; c_lvl = 128; c_num = 256; c_pre = 0;
    w_edge = 0; w_lvl = 128; w_num = 256; w_pre = 0;
    m_active = 0; m_done = 0; m_trig = 0; m_force = 0; m_pv = 0; m_prev = 0;
    n_pre = 0; n_post = 0;
    exp_wr = 0; exp_trig = 0; exp_data = 0;
  endtask

  always @(posedge clk_i) begin
    if (!rst) begin
      model_reset();
    end else begin
      is_req  = reg_si_rdy && reg_si_addr == 8'd3;
      stp     = is_req && reg_si_data[1];
      sta     = is_req && reg_si_data[0] && !reg_si_data[1];
      in_wait = m_active && !m_trig && n_pre >= w_pre;
      fired   = 0;
      exp_wr = 0; exp_trig = 0;
      if (stp) begin
        m_active = 0; m_done = 0; m_force = 0; m_pv = 0;
      end else if (sta) begin
        w_edge = c_edge; w_lvl = c_lvl; w_num = c_num; w_pre = c_pre;
        m_active = 1; m_done = 0; m_trig = 0; m_force = 0; m_pv = 0;
        n_pre = 0; n_post = 0;
      end else if (m_active && sample_rdy_i) begin
        exp_wr = 1; exp_data = sample_data_i; m_wr++;
        if (n_pre < w_pre) n_pre++;
        else if (!m_trig) begin
          if (m_force) fired = 1;
          else if (m_pv && w_edge == 0 && m_prev < w_lvl && int'(sample_data_i) >= w_lvl) fired = 1;
          else if (m_pv && w_edge == 1 && m_prev > w_lvl && int'(sample_data_i) <= w_lvl) fired = 1;
          if (fired) begin
            m_trig = 1; exp_trig = 1; m_force = 0; n_post = 1;
          end
        end else n_post++;
        tgt = (w_num > w_pre) ? (w_num - w_pre) : 1;
        if (m_trig && n_post == tgt) begin
          m_active = 0; m_done = 1;
        end
        m_prev = sample_data_i; m_pv = 1;
      end
      if (!stp && !sta && is_req && reg_si_data[2] && in_wait && !fired) m_force = 1;
      if (reg_si_rdy) begin
        case (reg_si_addr)
          8'd4: c_edge = int'(reg_si_data[0]);
          8'd5: c_lvl  = int'(reg_si_data[7:0]);
          8'd6: c_num  = int'(reg_si_data);
          8'd7: c_pre  = int'(reg_si_data);
          default: ;
        endcase
      end
    end
    exp_done = m_done;
    if (m_done) exp_state = 4;
    else if (!m_active) exp_state = 0;
    else if (m_trig) exp_state = 3;
    else if (n_pre < w_pre) exp_state = 1;
    else exp_state = 2;
  end

  // ---------------- compare process ----------------
  int o_wr, o_trig_cnt, o_trig_data;

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("state", int'(state_o), exp_state);
      chk("buf_wr", int'(buf_wr_o), int'(exp_wr));
      if (exp_wr) chk("buf_data", int'(buf_data_o), exp_data);
      chk("trigger", int'(trigger_o), int'(exp_trig));
      chk("done", int'(done_o), int'(exp_done));
      if (buf_wr_o) o_wr++;
      if (trigger_o) begin
        o_trig_cnt++;
        o_trig_data = int'(buf_data_o);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input int d, input bit w, input int a, input int wd);
    sample_rdy_i = r; sample_data_i = 8'(d);
    reg_si_rdy = w; reg_si_addr = 8'(a); reg_si_data = 16'(wd);
    @(negedge clk_i);
    #1;
  endtask

  task automatic samp(input int d); cyc(1, d, 0, 0, 0); endtask
  task automatic wreg(input int a, input int wd); cyc(0, 0, 1, a, wd); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0); endtask

  task automatic clr_obs();
    o_wr = 0; o_trig_cnt = 0; o_trig_data = -1; m_wr = 0;
  endtask

  task automatic setup(input int edge_sel, input int lvl, input int num, input int pre);
    wreg(4, edge_sel); wreg(5, lvl); wreg(6, num); wreg(7, pre);
  endtask

  int r, k;

  initial begin
    rst = 0;
    @(negedge clk_i); @(negedge clk_i); #1;
    chk_en = 1;
    idle();
    rst = 1;
    idle(); idle(); idle();
    chk("rst_state", int'(state_o), 0);
    chk("rst_done", int'(done_o), 0);

    // defaults: pre 0, num 256, level 128 rising
    clr_obs();
    wreg(3, 1);
    chk("dflt_wait", int'(state_o), 2);
    samp(100); samp(130);
    chk("dflt_trig", o_trig_data, 130);
    for (int i = 0; i < 254; i++) samp(i % 200);
    chk("dflt_nodone", int'(done_o), 0);
    samp(7);
    chk("dflt_done", int'(done_o), 1);
    chk("dflt_wr", o_wr, 257);
    chk("dflt_model_wr", m_wr, 257);

    // pre 4, num 10, level 100 rising, ramp
    setup(0, 100, 10, 4);
    clr_obs();
    wreg(3, 1);
    chk("ramp_pre", int'(state_o), 1);
    for (int i = 0; i < 14; i++) begin
      samp(i * 20);
      if (i == 3) chk("ramp_wait", int'(state_o), 2);
      if (i % 3 == 0) idle();
    end
    chk("ramp_trig", o_trig_data, 100);
    chk("ramp_wr", o_wr, 11);
    chk("ramp_model_wr", m_wr, 11);
    chk("ramp_done", int'(done_o), 1);

    // falling, level 50
    setup(1, 50, 3, 0);
    clr_obs();
    wreg(3, 1);
    samp(40); samp(50);
    chk("fall_none", o_trig_cnt, 0);
    samp(80); samp(60); samp(50);
    chk("fall_trig", o_trig_data, 50);
    samp(1); samp(2);
    chk("fall_done", int'(done_o), 1);
    chk("fall_cnt", o_trig_cnt, 1);

    // forced trigger with single-sample capture
    setup(0, 100, 1, 0);
    clr_obs();
    wreg(3, 1);
    samp(10); samp(10);
    wreg(3, 4);
    samp(10);
    chk("force_trig", int'(trigger_o), 1);
    chk("force_done", int'(done_o), 1);
    samp(10);
    chk("force_wr", o_wr, 3);

    // STOP in POST
    setup(0, 100, 7, 0);
    clr_obs();
    wreg(3, 1);
    samp(50); samp(150); samp(1); samp(2);
    wreg(3, 2);
    chk("stop_idle", int'(state_o), 0);
    samp(3); samp(4); samp(5);
    chk("stop_wr", o_wr, 4);
    chk("stop_done", int'(done_o), 0);
    wreg(3, 3);
    chk("startstop", int'(state_o), 0);

    // config write mid-capture
    setup(0, 100, 10, 0);
    clr_obs();
    wreg(3, 1);
    samp(0); samp(200);
    wreg(6, 20);
    for (int i = 0; i < 12; i++) samp(i);
    chk("midcfg_wr", o_wr, 11);
    clr_obs();
    wreg(3, 1);
    samp(0); samp(200);
    for (int i = 0; i < 25; i++) samp(i);
    chk("newcfg_wr", o_wr, 21);
    chk("newcfg_model", m_wr, 21);
    wreg(3, 1);
    samp(0); samp(0);
    rst = 0; idle(); rst = 1;
    chk("midrst_idle", int'(state_o), 0);
    clr_obs();
    wreg(3, 1);
    chk("midrst_dflt", int'(state_o), 2);
    samp(100); samp(130);
    chk("midrst_lvl", o_trig_data, 130);

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 5000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) samp($urandom_range(0, 255));
      else if (r < 70) idle();
      else if (r < 80) begin
        k = $urandom_range(4, 7);
        case (k)
          4: wreg(4, $urandom_range(0, 1));
          5: wreg(5, $urandom_range(0, 255));
          6: wreg(6, $urandom_range(0, 30));
          default: wreg(7, $urandom_range(0, 8));
        endcase
      end else if (r < 84) begin
        k = $urandom_range(0, 7);
        case (k)
          0, 1, 2: cyc(1'($urandom_range(0, 1)), $urandom_range(0, 255), 1, 3, 1);
          3, 4: cyc(1'($urandom_range(0, 1)), $urandom_range(0, 255), 1, 3, 4);
          5: wreg(3, 2);
          6: wreg(3, 3);
          default: wreg(3, 5);
        endcase
      end else if (r < 86) cyc(1, $urandom_range(0, 255), 1, 9, $urandom);
      else if (r == 86 && $urandom_range(0, 9) == 0) begin
        rst = 0; idle(); rst = 1;
      end else idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/acquisition_ctrl.md
Name: acquisition_ctrl

Overview:
- Sequences one oscilloscope capture on the conditioned sample stream from the ADC block (moving-average output).
- Handles pre-trigger fill, edge/level trigger detection and post-trigger sample counting.
- Emits a buffer write strobe per stored sample, plus trigger and done flags.
- Configured through the registers Simple Interface bus shared with the ADC block.

Parameters:
BITS_ADC, 8, sample width
REG_DATA_WIDTH, 16, register bus data width
REG_ADDR_WIDTH, 8, register bus address width
COUNTER_WIDTH, 16, width of sample counters (must be <= REG_DATA_WIDTH)
DEFAULT_PRETRIGGER, 0, pre-trigger sample count after reset
DEFAULT_NUM_SAMPLES, 256, total samples per capture after reset
DEFAULT_TRIGGER_VALUE, 128, trigger level after reset
ADDR_REQUEST, 3, command register (bit0 START, bit1 STOP, bit2 FORCE_TRIGGER; write-only pulses)
ADDR_TRIGGER_SETTINGS, 4, bit0 edge (0 rising, 1 falling)
ADDR_TRIGGER_VALUE, 5, trigger level [BITS_ADC-1:0]
ADDR_NUM_SAMPLES, 6, total samples [COUNTER_WIDTH-1:0]
ADDR_PRETRIGGER, 7, pre-trigger samples [COUNTER_WIDTH-1:0]

Ports:
clk_i  input  1  system clock
rst  input  1  synchronous reset, active-low
sample_data_i  input  BITS_ADC  sample from ADC block
sample_rdy_i  input  1  one-cycle sample valid
reg_si_data  input  REG_DATA_WIDTH  register write data
reg_si_addr  input  REG_ADDR_WIDTH  register address
reg_si_rdy  input  1  register write strobe
buf_data_o  output  BITS_ADC  sample to capture buffer
buf_wr_o  output  1  one-cycle write strobe
trigger_o  output  1  one-cycle pulse, coincident with buf_wr_o of the trigger sample
done_o  output  1  capture complete, level
state_o  output  3  current state encoding

Behaviour:
- Reset (rst==0 at clk_i edge):
  - State IDLE.
  - All outputs 0.
  - Config registers take their DEFAULT_* values.
  - Counters and prev_valid are cleared.
- States: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4.
- Config registers:
  - Writable in any state via reg_si_rdy with a matching address; non-matching addresses are ignored.
  - On START, each config register is copied into a working copy. Mid-capture config writes therefore take effect only at the next START.
- Command register:
  - STOP has priority over START in the same write.
  - STOP: any state -> IDLE next cycle; no buffer write that cycle; done_o cleared.
  - START from any state (including mid-capture) -> next state PRE, or WAIT_TRIG if working PRETRIGGER==0. Counters clear, prev_valid clears, done_o clears.
  - A sample arriving in the same cycle as a START write is not stored.
- Sample acceptance:
  - Only in PRE, WAIT_TRIG and POST, and only on sample_rdy_i==1.
  - Each accepted sample is registered to buf_data_o with buf_wr_o=1 on the next cycle (latency 1).
  - Samples are never accepted in IDLE or DONE.
- PRE:
  - Counts accepted samples.
  - When the count reaches working PRETRIGGER -> WAIT_TRIG.
  - Trigger conditions and FORCE_TRIGGER are ignored in PRE.
- WAIT_TRIG: accepted samples are written (the buffer wraps circularly). Trigger fires on an accepted sample when:
  - rising: prev_valid && prev < level && cur >= level;
  - falling: prev_valid && prev > level && cur <= level;
  - or FORCE_TRIGGER has been latched (latch is set by a write in WAIT_TRIG; the next accepted sample fires).
  - All comparisons are unsigned.
  - prev is updated on every accepted sample; prev_valid is set after the first accepted sample of a capture.
- Trigger sample: written with trigger_o=1. State -> POST with post counter = NUM_SAMPLES - PRETRIGGER - 1. If NUM_SAMPLES <= PRETRIGGER+1, the state goes directly to DONE after the trigger sample.
- POST: each accepted sample decrements the post counter; the sample that brings it to 0 is the last one written. Next state DONE.
- DONE: done_o=1 (asserted the same cycle as the final buf_wr_o) and held until START, STOP or reset.
- Total written after the trigger, including the trigger sample, = max(NUM_SAMPLES - PRETRIGGER, 1).
- Counter arithmetic is COUNTER_WIDTH unsigned; no wrap can occur since counters load from ≤ max values.
- Reset mid-capture overrides everything: IDLE, outputs 0, defaults restored.

Test Plan:
- Reset with rst=0, then rst=1, no writes -> state_o=0, buf_wr_o=0, done_o=0. A readback of the config working copies after START shows 0 / 256 / 128.
- PRETRIGGER=4, NUM_SAMPLES=10, level=100, rising; START; feed ramp 0,20,40,...; -> 4 writes in PRE, then WAIT_TRIG. trigger_o on sample 100 (prev 80). Exactly 6 writes from the trigger onward. done_o set with the 6th write; no further writes.
- Falling edge, level=50; feed 80,60,50 -> trigger on 50. Sample sequence 40,50 -> no trigger.
- PRETRIGGER=0, NUM_SAMPLES=1, FORCE_TRIGGER in WAIT_TRIG with flat input 10 -> next sample written with trigger_o=1, done_o=1 on the same cycle.
- STOP in POST after 2 of 6 post samples -> IDLE next cycle, no further writes, done_o=0. A START with STOP in the same write keeps the block in IDLE.
- Write NUM_SAMPLES=20 during POST of a 10-sample capture -> the current capture still ends after 10. A subsequent START captures 20. rst=0 mid-capture -> IDLE, defaults restored.
